// File: rtl/trojan_scan_scheduler.sv
// Time-shares one pipelined benchmark subcircuit between NREQ test requesters.
// A round-robin arbiter picks a requester. Its vector is held on dut_in for DEPTH
// cycles so the response crosses every flop stage. The 1-bit response is then
// compared with the requester's golden bit. Mismatches feed a saturating counter.
//
// Handshake: each req bit is a level that the requester holds until it sees its
// one-cycle gnt pulse. The vector and golden bit are sampled on the same edge
// that raises gnt. A req still high after its gnt counts as a new request and
// waits for its next round-robin turn. done is a one-cycle strobe, and
// done_id/mismatch are meaningful only while done is high.
module trojan_scan_scheduler #(
  parameter int NREQ  = 4,
  parameter int VEC_W = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     I1470_clk,
  input  logic                     I1477_rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*VEC_W-1:0]    req_vec,
  input  logic [NREQ-1:0]          req_golden,
  input  logic                     clr_cnt,
  output logic [NREQ-1:0]          gnt,
  output logic [VEC_W-1:0]         dut_in,
  output logic                     dut_en,
  input  logic                     dut_out,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic                     mismatch,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     busy,
  output logic [1:0]               state_dbg
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_REPORT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               gold_q, gold_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [VEC_W-1:0]   dut_in_q, dut_in_d;
  logic               dut_en_q, dut_en_d;
  logic               done_q, done_d;
  logic [IDW-1:0]     done_id_q, done_id_d;
  logic               mismatch_q, mismatch_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               busy_q, busy_d;

  // Arbiter signals
  logic               arb_found;
  logic [IDW-1:0]     arb_win;
  logic [IDW-1:0]     arb_idx;
  logic [VEC_W-1:0]   vec_arr [NREQ];

  // Unpack the flat vector bus into one entry per requester
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign vec_arr[g] = req_vec[g*VEC_W +: VEC_W];
  end

  // Round-robin search: start at ptr, wrap modulo NREQ, first set req wins
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    arb_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      arb_idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!arb_found && req[arb_idx]) begin
        arb_found = 1'b1;
        arb_win   = arb_idx;
      end
    end
  end

  // Next-state and registered-output logic of the test sequencer
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    gold_d     = gold_q;
    id_d       = id_q;
    gnt_d      = '0;
    dut_in_d   = dut_in_q;
    dut_en_d   = dut_en_q;
    done_d     = 1'b0;
    done_id_d  = done_id_q;
    mismatch_d = mismatch_q;
    unique case (state_q)
      S_IDLE: begin
        dut_in_d = '0;
        dut_en_d = 1'b0;
        if (arb_found) begin
          state_d          = S_DRIVE;
          gnt_d[arb_win]   = 1'b1;
          gold_d           = req_golden[arb_win];
          id_d             = arb_win;
          cnt_d            = CW'(DEPTH - 1);
          dut_in_d         = vec_arr[arb_win];
          dut_en_d         = 1'b1;
          ptr_d            = (arb_win == IDW'(NREQ - 1)) ? '0 : arb_win + 1'b1;
        end
      end
      S_DRIVE: begin
        // Down-counter holds the vector for exactly DEPTH cycles
        if (cnt_q == '0) begin
          state_d  = S_CAPTURE;
          dut_en_d = 1'b0;
          dut_in_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CAPTURE: begin
        state_d    = S_REPORT;
        done_d     = 1'b1;
        done_id_d  = id_q;
        mismatch_d = dut_out ^ gold_q;
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Saturating mismatch counter; a clear wins over a coincident increment
  always_comb begin
    err_d = err_q;
    if (state_q == S_REPORT && mismatch_q && err_q != CNT_MAX) begin
      err_d = err_q + 1'b1;
    end
    if (clr_cnt) begin
      err_d = '0;
    end
  end

  // State and output registers; reset aborts any test in flight silently
  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      gold_q     <= 1'b0;
      id_q       <= '0;
      gnt_q      <= '0;
      dut_in_q   <= '0;
      dut_en_q   <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      gold_q     <= gold_d;
      id_q       <= id_d;
      gnt_q      <= gnt_d;
      dut_in_q   <= dut_in_d;
      dut_en_q   <= dut_en_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign dut_in    = dut_in_q;
  assign dut_en    = dut_en_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign mismatch  = mismatch_q;
  assign err_cnt   = err_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_trojan_scan_scheduler.sv
// Directed bench for trojan_scan_scheduler: reset abort, single test timing,
// round-robin order, mismatch counting, saturation/clear and late requests.
module tb_trojan_scan_scheduler;

  localparam int NREQ  = 4;
  localparam int VEC_W = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [NREQ*VEC_W-1:0]   req_vec;
  logic [NREQ-1:0]         req_golden;
  logic                    clr_cnt;
  logic [NREQ-1:0]         gnt;
  logic [VEC_W-1:0]        dut_in;
  logic                    dut_en;
  logic                    dut_out;
  logic                    done;
  logic [1:0]              done_id;
  logic                    mismatch;
  logic [CNT_W-1:0]        err_cnt;
  logic                    busy;
  logic [1:0]              state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [NREQ-1:0] exp_q[$];

  trojan_scan_scheduler #(
    .NREQ(NREQ), .VEC_W(VEC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) u_dut (
    .I1470_clk (clk),
    .I1477_rst (rst),
    .req       (req),
    .req_vec   (req_vec),
    .req_golden(req_golden),
    .clr_cnt   (clr_cnt),
    .gnt       (gnt),
    .dut_in    (dut_in),
    .dut_en    (dut_en),
    .dut_out   (dut_out),
    .done      (done),
    .done_id   (done_id),
    .mismatch  (mismatch),
    .err_cnt   (err_cnt),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  // Driver: raise req[id], drop it after gnt, stop on the done cycle
  task automatic run_one(input int id, output logic got_done, output logic got_mm,
                         output logic [1:0] got_id);
    got_done = 1'b0;
    got_mm   = 1'b0;
    got_id   = '0;
    req[id]  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (gnt != '0) break;
    end
    req = '0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        got_done = 1'b1;
        got_mm   = mismatch;
        got_id   = done_id;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [NREQ+VEC_W+1+1+2+1+CNT_W+1-1:0] outs;
    logic saw_done;
    logic got_done, got_mm;
    logic [1:0] got_id;
    rst = 1'b1; req = '0; req_vec = '0; req_golden = '0; clr_cnt = 1'b0; dut_out = 1'b0;
    repeat (2) tick();
    outs = {gnt, dut_in, dut_en, done, done_id, mismatch, err_cnt, busy};
    n_cmp++;
    if (outs !== '0) begin n_err++; $display("FAIL reset_outs: got %0h expected 0", outs); end
    rst = 1'b0;
    tick();
    req = 4'b0001; req_vec = 16'h0005;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001) begin n_err++; $display("FAIL reset_pre_gnt: got %b expected 0001", gnt); end
    req = '0;
    repeat (2) tick();
    n_cmp++;
    if (dut_en !== 1'b1 || state_dbg !== 2'd1) begin
      n_err++; $display("FAIL reset_pre_drive: got en=%b st=%0d expected en=1 st=1", dut_en, state_dbg);
    end
    rst = 1'b1;
    #1;
    outs = {gnt, dut_in, dut_en, done, done_id, mismatch, err_cnt, busy};
    n_cmp++;
    if (outs !== '0 || state_dbg !== 2'd0) begin
      n_err++; $display("FAIL reset_async: got outs=%0h st=%0d expected 0 0", outs, state_dbg);
    end
    tick();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin n_err++; $display("FAIL reset_no_done: got 1 expected 0"); end
    req = 4'b0001;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001) begin n_err++; $display("FAIL reset_post_gnt: got %b expected 0001", gnt); end
    req = '0;
    for (int c = 0; c < 20; c++) begin
      if (done) break;
      tick();
    end
    n_cmp++;
    if (done !== 1'b1 || err_cnt !== 8'd0) begin
      n_err++; $display("FAIL reset_post_done: got done=%b err=%0d expected 1 0", done, err_cnt);
    end
    tick();
    got_done = 1'b0; got_mm = 1'b0; got_id = '0;
  endtask

  task automatic test_single();
    req_vec = 16'h00A0; req_golden = 4'b0010; dut_out = 1'b1;
    req = 4'b0010;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010) begin n_err++; $display("FAIL single_gnt: got %b expected 0010", gnt); end
    req = '0;
    for (int c = 1; c <= DEPTH; c++) begin
      n_cmp++;
      if (dut_en !== 1'b1 || dut_in !== 4'hA) begin
        n_err++; $display("FAIL single_drive%0d: got en=%b in=%h expected 1 a", c, dut_en, dut_in);
      end
      if (c > 1) begin
        n_cmp++;
        if (gnt !== '0) begin n_err++; $display("FAIL single_gnt_pulse: got %b expected 0000", gnt); end
      end
      tick();
    end
    n_cmp++;
    if (dut_en !== 1'b0 || dut_in !== 4'h0 || done !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL single_capture: got en=%b in=%h done=%b busy=%b expected 0 0 0 1",
                        dut_en, dut_in, done, busy);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || done_id !== 2'd1 || mismatch !== 1'b0 || err_cnt !== 8'd0) begin
      n_err++; $display("FAIL single_done: got done=%b id=%0d mm=%b err=%0d expected 1 1 0 0",
                        done, done_id, mismatch, err_cnt);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || done_id !== 2'd1) begin
      n_err++; $display("FAIL single_after: got done=%b busy=%b id=%0d expected 0 0 1", done, busy, done_id);
    end
  endtask

  task automatic test_rr();
    int cyc, last, cnt;
    logic [NREQ-1:0] exp_g;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_golden = '0; dut_out = 1'b0; req_vec = 16'h4321;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    req = 4'b1111;
    cyc = 0; last = 0; cnt = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      cyc++;
      if (gnt != '0) begin
        exp_g = exp_q.pop_front();
        n_cmp++;
        if (gnt !== exp_g) begin n_err++; $display("FAIL rr_order%0d: got %b expected %b", cnt, gnt, exp_g); end
        n_cmp++;
        if (cnt == 0 && cyc !== 1) begin n_err++; $display("FAIL rr_first: got cycle %0d expected 1", cyc); end
        else if (cnt != 0 && cyc - last !== DEPTH + 3) begin
          n_err++; $display("FAIL rr_spacing%0d: got %0d expected %0d", cnt, cyc - last, DEPTH + 3);
        end
        last = cyc;
        cnt++;
        if (cnt == 5) break;
      end
    end
    req = '0;
    n_cmp++;
    if (cnt !== 5) begin n_err++; $display("FAIL rr_count: got %0d expected 5", cnt); end
    exp_q.delete();
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!busy) break;
    end
  endtask

  task automatic test_mismatch();
    logic got_done, got_mm;
    logic [1:0] got_id;
    req_golden = '0; dut_out = 1'b1;
    run_one(0, got_done, got_mm, got_id);
    n_cmp++;
    if (got_done !== 1'b1 || got_mm !== 1'b1 || got_id !== 2'd0 || err_cnt !== 8'd0) begin
      n_err++; $display("FAIL mm_done: got done=%b mm=%b id=%0d err=%0d expected 1 1 0 0",
                        got_done, got_mm, got_id, err_cnt);
    end
    tick();
    n_cmp++;
    if (err_cnt !== 8'd1 || mismatch !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL mm_count: got err=%0d mm=%b done=%b expected 1 1 0", err_cnt, mismatch, done);
    end
  endtask

  task automatic test_saturation();
    logic got_done, got_mm;
    logic [1:0] got_id;
    int n_done;
    req_golden = '0; dut_out = 1'b1;
    n_done = 0;
    for (int i = 0; i < 254; i++) begin
      run_one(0, got_done, got_mm, got_id);
      if (got_done && got_mm) n_done++;
    end
    tick();
    n_cmp++;
    if (n_done !== 254 || err_cnt !== 8'd255) begin
      n_err++; $display("FAIL sat_preload: got done=%0d err=%0d expected 254 255", n_done, err_cnt);
    end
    run_one(0, got_done, got_mm, got_id);
    tick();
    n_cmp++;
    if (got_mm !== 1'b1 || err_cnt !== 8'd255) begin
      n_err++; $display("FAIL sat_hold: got mm=%b err=%0d expected 1 255", got_mm, err_cnt);
    end
    run_one(0, got_done, got_mm, got_id);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    n_cmp++;
    if (got_done !== 1'b1 || err_cnt !== 8'd0) begin
      n_err++; $display("FAIL sat_clear: got done=%b err=%0d expected 1 0", got_done, err_cnt);
    end
  endtask

  task automatic test_late();
    req_golden = '0; dut_out = 1'b0;
    req = 4'b0001;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001) begin n_err++; $display("FAIL late_gnt0: got %b expected 0001", gnt); end
    req = '0;
    tick();
    req = 4'b1000;
    for (int c = 2; c <= DEPTH + 3; c++) begin
      n_cmp++;
      if (gnt !== '0) begin n_err++; $display("FAIL late_quiet%0d: got %b expected 0000", c, gnt); end
      tick();
    end
    n_cmp++;
    if (gnt !== 4'b1000) begin n_err++; $display("FAIL late_gnt3: got %b expected 1000", gnt); end
    req = '0;
    for (int c = 0; c < 20; c++) begin
      if (done) break;
      tick();
    end
    n_cmp++;
    if (done !== 1'b1 || done_id !== 2'd3 || mismatch !== 1'b0 || err_cnt !== 8'd0) begin
      n_err++; $display("FAIL late_done: got done=%b id=%0d mm=%b err=%0d expected 1 3 0 0",
                        done, done_id, mismatch, err_cnt);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_mismatch();
    test_saturation();
    test_late();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
